// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants, response record and helpers for the shared-adder arbiter.
package adder_share_arbiter_pkg;

  localparam int ADDER_W = 32;
  // Widest requester index supported (NREQ up to 8).
  localparam int MAX_IDW = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [ADDER_W-1:0] sum;
    logic               cout;
    logic               ovf;
    logic [MAX_IDW-1:0] id;
  } rsp_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping modulo NREQ. Grant and index are zero when disabled or idle.
module rr_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW:0]      pos;
  logic              found;

  always_comb begin
    // Rotate so bit k of rot is requester (ptr+k) mod NREQ.
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[NREQ-1:0];
    found = 1'b0;
    pos   = '0;
    idx_o = '0;
    gnt_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = {1'b0, ptr_i} + (IDW+1)'(k);
        if (pos >= (IDW+1)'(NREQ)) begin
          pos = pos - (IDW+1)'(NREQ);
        end
        idx_o = pos[IDW-1:0];
      end
    end
    if (en_i && found) begin
      gnt_o = NREQ'(1) << idx_o;
    end else begin
      idx_o = '0;
    end
  end

endmodule

// File: rtl/bitwithoutmuxcarrylook1.sv
// 32-bit carry-lookahead adder without carry-in: 4-bit lookahead groups,
// group generate/propagate chained between groups.
module bitwithoutmuxcarrylook1 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] p;
  logic [31:0] g;
  logic [31:0] c;
  logic [8:0]  cg;
  logic [7:0]  gg;
  logic [7:0]  gp;

  assign p     = a_i ^ b_i;
  assign g     = a_i & b_i;
  assign cg[0] = 1'b0;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B]   = cg[k];
    assign c[B+1] = g[B] | (p[B] & cg[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & cg[k]);
    assign gg[k]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[k]  = &p[B+3:B];
    assign cg[k+1] = gg[k] | (gp[k] & cg[k]);
  end

  assign sum_o  = p ^ c;
  assign cout_o = cg[8];

endmodule

// File: rtl/adder_share_arbiter.sv
// One shared 32-bit lookahead adder time-multiplexed across NREQ requesters
// with round-robin arbitration and a single registered response slot.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*ADDER_W-1:0] req_a,
  input  logic [NREQ*ADDER_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ADDER_W-1:0]      rsp_sum,
  output logic                    rsp_cout,
  output logic                    rsp_ovf,
  output logic [IDW-1:0]          rsp_id
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // req_ready is a Mealy function of req_valid, so requesters must not
  // derive req_valid from req_ready and must hold operands until accepted.
  // The response slot may be refilled on the same edge it drains.

  slot_state_e         slot_q, slot_d;
  rsp_t                rsp_q, rsp_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]     gnt;
  logic [IDW-1:0]      gnt_idx;
  logic                can_issue;
  logic                issue;
  logic [ADDER_W-1:0]  a_sel;
  logic [ADDER_W-1:0]  b_sel;
  logic [ADDER_W-1:0]  sum;
  logic                cout;
  logic                ovf;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (can_issue && !rst),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign issue     = |gnt;
  assign req_ready = gnt;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*ADDER_W +: ADDER_W];
        b_sel = req_b[i*ADDER_W +: ADDER_W];
      end
    end
  end

  bitwithoutmuxcarrylook1 u_add (
    .a_i    (a_sel),
    .b_i    (b_sel),
    .sum_o  (sum),
    .cout_o (cout)
  );

  assign ovf = (a_sel[ADDER_W-1] == b_sel[ADDER_W-1]) &&
               (sum[ADDER_W-1] != a_sel[ADDER_W-1]);

  // Slot FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Slot FSM: next state
  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (issue) slot_d = SLOT_FULL;
      SLOT_FULL:  if (!issue && rsp_ready) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  // Slot FSM: outputs
  always_comb begin
    rsp_valid = (slot_q == SLOT_FULL);
    can_issue = (slot_q == SLOT_EMPTY) || rsp_ready;
    rsp_sum   = rsp_q.sum;
    rsp_cout  = rsp_q.cout;
    rsp_ovf   = rsp_q.ovf;
    rsp_id    = IDW'(rsp_q.id);
  end

  // Fields only move on issue, so a drained or stalled slot keeps its value.
  always_comb begin
    rsp_d    = rsp_q;
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rsp_d.sum  = sum;
      rsp_d.cout = cout;
      rsp_d.ovf  = ovf;
      rsp_d.id   = MAX_IDW'(gnt_idx);
      rr_ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      rsp_q    <= rsp_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
